// File: rtl/dyn_phase_ctrl.sv
// dyn_phase_ctrl: steps one PLL output counter phase up or down per request.
// Optional build macro DYN_PHASE_CTRL_TIMEOUT_EN bounds the PHASEDONE waits.
//
// Ports:
//   CLK50M                 clock, rising edge (also the PLL scanclk)
//   RESET_N                asynchronous active-low reset
//   COUNTER[3:0]           counter select, legal 0..6
//   DYN_PHASE[1:0]         request, 01 = up, 10 = down
//   PLL_PHASEDONE          PLL phasedone, low while shifting
//   PLL_PHASECOUNTERSELECT latched counter select
//   PLL_PHASEUPDOWN        latched direction, 1 = up
//   PLL_PHASESTEP          phasestep strobe
//   BUSY                   high outside IDLE
//   DONE                   one-cycle pulse per completed shift
//   ERR                    sticky error, cleared by reset only
//   DROP                   one-cycle pulse per discarded request
//   STEP_POS[7:0]          signed net step count, wraps
module dyn_phase_ctrl #(
    parameter int P_STEP_CYCLES = 2,
    parameter int P_TIMEOUT     = 255
) (
    input  logic       CLK50M,
    input  logic       RESET_N,
    input  logic [3:0] COUNTER,
    input  logic [1:0] DYN_PHASE,
    input  logic       PLL_PHASEDONE,
    output logic [2:0] PLL_PHASECOUNTERSELECT,
    output logic       PLL_PHASEUPDOWN,
    output logic       PLL_PHASESTEP,
    output logic       BUSY,
    output logic       DONE,
    output logic       ERR,
    output logic       DROP,
    output logic [7:0] STEP_POS
);

    if (P_STEP_CYCLES < 2 || P_STEP_CYCLES > 15 || P_TIMEOUT < 1) begin : g_bad_param
        $error("dyn_phase_ctrl: illegal parameter value");
    end

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STEP,
        WAIT_LOW,
        WAIT_HIGH,
        FIN
    } state_t;

    localparam logic [3:0] STEP_LAST = 4'(P_STEP_CYCLES - 1);

`ifdef DYN_PHASE_CTRL_TIMEOUT_EN
    localparam int TW = $clog2(P_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(P_TIMEOUT - 1);
    logic [TW-1:0] tmo;
`endif

    state_t     state;
    logic [3:0] step_cnt;
    logic [1:0] dyn_q;
    logic [1:0] dyn_prev;
    logic       started;
    logic       req;

    // dyn_prev holds 11 until one real sample has been taken after reset,
    // so a level held through reset cannot look like a fresh 00->01 edge.
    assign req = (dyn_prev == 2'b00) &&
                 (dyn_q == 2'b01 || dyn_q == 2'b10);

    always_ff @(posedge CLK50M or negedge RESET_N) begin
        if (!RESET_N) begin
            state                  <= IDLE;
            step_cnt               <= '0;
            dyn_q                  <= 2'b00;
            dyn_prev               <= 2'b11;
            started                <= 1'b0;
            PLL_PHASECOUNTERSELECT <= '0;
            PLL_PHASEUPDOWN        <= 1'b0;
            PLL_PHASESTEP          <= 1'b0;
            BUSY                   <= 1'b0;
            DONE                   <= 1'b0;
            ERR                    <= 1'b0;
            DROP                   <= 1'b0;
            STEP_POS               <= '0;
`ifdef DYN_PHASE_CTRL_TIMEOUT_EN
            tmo                    <= '0;
`endif
        end else begin
            started  <= 1'b1;
            dyn_q    <= DYN_PHASE;
            dyn_prev <= started ? dyn_q : 2'b11;
            DONE     <= 1'b0;
            DROP     <= 1'b0;

            if (req && state != IDLE) begin
                DROP <= 1'b1;
            end

            unique case (state)
                IDLE: begin
                    if (req) begin
                        if (COUNTER > 4'd6) begin
                            ERR  <= 1'b1;
                            DROP <= 1'b1;
                        end else begin
                            PLL_PHASECOUNTERSELECT <= COUNTER[2:0];
                            PLL_PHASEUPDOWN        <= (dyn_q == 2'b01);
                            BUSY                   <= 1'b1;
                            state                  <= SETUP;
                        end
                    end
                end
                SETUP: begin
                    PLL_PHASESTEP <= 1'b1;
                    step_cnt      <= '0;
                    state         <= STEP;
                end
                STEP: begin
                    if (step_cnt == STEP_LAST) begin
                        PLL_PHASESTEP <= 1'b0;
                        state         <= WAIT_LOW;
`ifdef DYN_PHASE_CTRL_TIMEOUT_EN
                        tmo           <= '0;
`endif
                    end else begin
                        step_cnt <= step_cnt + 4'd1;
                    end
                end
                WAIT_LOW: begin
                    if (!PLL_PHASEDONE) begin
                        state <= WAIT_HIGH;
`ifdef DYN_PHASE_CTRL_TIMEOUT_EN
                        tmo   <= '0;
                    end else if (tmo == TMO_LAST) begin
                        ERR   <= 1'b1;
                        BUSY  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        tmo <= tmo + 1'b1;
`endif
                    end
                end
                WAIT_HIGH: begin
                    if (PLL_PHASEDONE) begin
                        DONE     <= 1'b1;
                        STEP_POS <= PLL_PHASEUPDOWN ? STEP_POS + 8'd1
                                                    : STEP_POS - 8'd1;
                        state    <= FIN;
`ifdef DYN_PHASE_CTRL_TIMEOUT_EN
                    end else if (tmo == TMO_LAST) begin
                        ERR   <= 1'b1;
                        BUSY  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        tmo <= tmo + 1'b1;
`endif
                    end
                end
                FIN: begin
                    BUSY  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dyn_phase_ctrl.sv
// tb_dyn_phase_ctrl: directed self-checking bench for dyn_phase_ctrl.
// Expected shift results are queued at request time and popped on DONE.
module tb_dyn_phase_ctrl;

    logic       CLK50M = 1'b0;
    logic       RESET_N;
    logic [3:0] COUNTER;
    logic [1:0] DYN_PHASE;
    logic       PLL_PHASEDONE;
    logic [2:0] PLL_PHASECOUNTERSELECT;
    logic       PLL_PHASEUPDOWN;
    logic       PLL_PHASESTEP;
    logic       BUSY;
    logic       DONE;
    logic       ERR;
    logic       DROP;
    logic [7:0] STEP_POS;

    dyn_phase_ctrl dut (
        .CLK50M                 (CLK50M),
        .RESET_N                (RESET_N),
        .COUNTER                (COUNTER),
        .DYN_PHASE              (DYN_PHASE),
        .PLL_PHASEDONE          (PLL_PHASEDONE),
        .PLL_PHASECOUNTERSELECT (PLL_PHASECOUNTERSELECT),
        .PLL_PHASEUPDOWN        (PLL_PHASEUPDOWN),
        .PLL_PHASESTEP          (PLL_PHASESTEP),
        .BUSY                   (BUSY),
        .DONE                   (DONE),
        .ERR                    (ERR),
        .DROP                   (DROP),
        .STEP_POS               (STEP_POS)
    );

    always #5 CLK50M = ~CLK50M;

    typedef struct {
        logic [2:0] sel;
        logic       ud;
        logic [7:0] pos;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] model_pos = 8'd0;
    int         n_chk = 0;
    int         n_bad = 0;
    int         done_cnt = 0;
    int         drop_cnt = 0;
    time        t_done = 0;
    time        t_req = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge CLK50M) begin
        if (RESET_N === 1'b1) begin
            if (BUSY && sb.size() > 0) begin
                chk("sel_hold", PLL_PHASECOUNTERSELECT, sb[0].sel);
                chk("ud_hold", PLL_PHASEUPDOWN, sb[0].ud);
            end
            if (DONE) begin
                exp_t e;
                done_cnt++;
                t_done = $time;
                chk("sb_nonempty", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("done_sel", PLL_PHASECOUNTERSELECT, e.sel);
                    chk("done_ud", PLL_PHASEUPDOWN, e.ud);
                    chk("done_pos", STEP_POS, e.pos);
                end
            end
            if (DROP) drop_cnt++;
        end
    end

    task automatic do_req(input logic [1:0] dir, input logic [3:0] ctr,
                          input bit push);
        @(negedge CLK50M);
        COUNTER   = ctr;
        DYN_PHASE = dir;
        t_req     = $time;
        if (push) begin
            model_pos = (dir == 2'b01) ? model_pos + 8'd1 : model_pos - 8'd1;
            sb.push_back('{ctr[2:0], dir == 2'b01, model_pos});
        end
        @(negedge CLK50M);
        DYN_PHASE = 2'b00;
    endtask

    task automatic wait_fall();
        int t = 0;
        int hi = 0;
        while (!PLL_PHASESTEP && t < 50) begin
            @(negedge CLK50M);
            t++;
        end
        chk("step_rise", PLL_PHASESTEP, 1);
        while (PLL_PHASESTEP && hi < 50) begin
            hi++;
            @(negedge CLK50M);
        end
        chk("step_len", hi, 2);
    endtask

    task automatic finish_pll(input int lo_dly, input int hi_len);
        int t = 0;
        repeat (lo_dly) @(negedge CLK50M);
        PLL_PHASEDONE = 1'b0;
        repeat (hi_len) @(negedge CLK50M);
        PLL_PHASEDONE = 1'b1;
        while (BUSY && t < 50) begin
            @(negedge CLK50M);
            t++;
        end
        chk("idle_after_shift", BUSY, 0);
    endtask

    task automatic do_reset();
        @(negedge CLK50M);
        RESET_N = 1'b0;
        @(negedge CLK50M);
        chk("rst_pos", STEP_POS, 0);
        chk("rst_err", ERR, 0);
        chk("rst_busy", BUSY, 0);
        sb.delete();
        model_pos = 8'd0;
        RESET_N = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int n0;
        int t;
        RESET_N       = 1'b0;
        COUNTER       = 4'd0;
        DYN_PHASE     = 2'b01;
        PLL_PHASEDONE = 1'b1;
        repeat (3) @(negedge CLK50M);
        chk("rst_sel", PLL_PHASECOUNTERSELECT, 0);
        chk("rst_ud", PLL_PHASEUPDOWN, 0);
        chk("rst_step", PLL_PHASESTEP, 0);
        chk("rst_busy0", BUSY, 0);
        chk("rst_done", DONE, 0);
        chk("rst_err0", ERR, 0);
        chk("rst_drop", DROP, 0);
        chk("rst_pos0", STEP_POS, 0);

        // Level held through reset release must not start a shift.
        RESET_N = 1'b1;
        repeat (5) begin
            @(negedge CLK50M);
            chk("held_level_busy", BUSY, 0);
        end
        chk("held_level_drop", drop_cnt, 0);
        DYN_PHASE = 2'b00;
        repeat (2) @(negedge CLK50M);

        // Up on counter 2, PHASEDONE low 3 cycles after step, 5 cycles low.
        do_req(2'b01, 4'd2, 1);
        wait_fall();
        finish_pll(3, 5);
        chk("t1_done_cnt", done_cnt, 1);
        chk("t1_pos", STEP_POS, 8'h01);

        // Minimum latency from request to DONE.
        do_req(2'b01, 4'd5, 1);
        wait_fall();
        finish_pll(0, 1);
        chk("latency", int'((t_done - t_req) / 10), 7);

        // Three downs on counter 3 from a clean reset.
        do_reset();
        d0 = done_cnt;
        repeat (3) begin
            do_req(2'b10, 4'd3, 1);
            wait_fall();
            finish_pll(2, 2);
        end
        chk("t3_pos", STEP_POS, 8'hFD);
        chk("t3_done_cnt", done_cnt - d0, 3);
        chk("t3_err", ERR, 0);

        // Second request arriving during WAIT_LOW is dropped.
        d0 = drop_cnt;
        n0 = done_cnt;
        do_req(2'b01, 4'd3, 1);
        wait_fall();
        do_req(2'b01, 4'd3, 0);
        finish_pll(3, 2);
        repeat (3) @(negedge CLK50M);
        chk("t4_drop", drop_cnt - d0, 1);
        chk("t4_done", done_cnt - n0, 1);
        chk("t4_pos", STEP_POS, 8'hFE);

        // Illegal counter select.
        d0 = drop_cnt;
        do_req(2'b01, 4'd7, 0);
        repeat (6) begin
            @(negedge CLK50M);
            chk("t5_busy", BUSY, 0);
            chk("t5_step", PLL_PHASESTEP, 0);
        end
        chk("t5_drop", drop_cnt - d0, 1);
        chk("t5_err", ERR, 1);

        // ERR stays set across a later good shift.
        do_req(2'b01, 4'd0, 1);
        wait_fall();
        finish_pll(1, 1);
        chk("t5_err_sticky", ERR, 1);
        chk("t5_pos", STEP_POS, 8'hFF);

        // Reset in the middle of STEP.
        do_req(2'b01, 4'd1, 1);
        t = 0;
        while (!PLL_PHASESTEP && t < 20) begin
            @(negedge CLK50M);
            t++;
        end
        chk("t6_in_step", PLL_PHASESTEP, 1);
        #2 RESET_N = 1'b0;
        #1;
        chk("t6_step_async", PLL_PHASESTEP, 0);
        chk("t6_busy", BUSY, 0);
        chk("t6_pos", STEP_POS, 0);
        chk("t6_err", ERR, 0);
        sb.delete();
        model_pos = 8'd0;
        @(negedge CLK50M);
        RESET_N = 1'b1;
        do_req(2'b10, 4'd4, 1);
        wait_fall();
        finish_pll(1, 1);
        chk("t6_after_pos", STEP_POS, 8'hFF);

        // Wrap from 127 to -128.
        repeat (128) begin
            do_req(2'b01, 4'd6, 1);
            wait_fall();
            finish_pll(0, 1);
        end
        chk("wrap_127", STEP_POS, 8'h7F);
        do_req(2'b01, 4'd6, 1);
        wait_fall();
        finish_pll(0, 1);
        chk("wrap_m128", STEP_POS, 8'h80);

        // PHASEDONE never drops.
        do_reset();
        n0 = done_cnt;
        do_req(2'b01, 4'd2, 1);
        wait_fall();
`ifdef DYN_PHASE_CTRL_TIMEOUT_EN
        t = 0;
        while (BUSY && t < 400) begin
            @(negedge CLK50M);
            t++;
        end
        chk("tmo_idle", BUSY, 0);
        chk("tmo_cycles", t, 255);
        chk("tmo_err", ERR, 1);
        chk("tmo_no_done", done_cnt - n0, 0);
        chk("tmo_pos", STEP_POS, 0);
        sb.delete();
`else
        repeat (300) @(negedge CLK50M);
        chk("notmo_busy", BUSY, 1);
        chk("notmo_no_done", done_cnt - n0, 0);
        chk("notmo_err", ERR, 0);
        do_reset();
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
